// File: rtl/sram_weight_pkg.sv
// Shared definitions for the weight SRAM burst streamer: default geometry,
// stream FSM state encoding and the parity helper used when the
// SRAM_WEIGHT_PARITY_EN build option is defined.
package sram_weight_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 156800;
    localparam int DEF_ADDR_W = 18;
    localparam int DEF_LEN_W  = 18;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int PAR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Even parity bit: makes the XOR of word plus bit equal to zero.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sram_weight_skid_fifo.sv
// Two-entry output FIFO for the weight streamer. Entry 0 is the registered
// head seen by the consumer, so out_data never changes while out_valid is
// high and out_ready is low. The caller guarantees no push when full.
module sram_weight_skid_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_r;
    logic [W-1:0] ent1_r;
    logic [1:0]   cnt_r;
    logic [1:0]   cnt_s;
    logic         valid_r;
    logic         pop_s;

    assign pop_s     = valid_r && out_ready;
    assign out_valid = valid_r;
    assign out_data  = ent0_r;
    assign count     = cnt_r;

    // Next occupancy from this cycle's push and pop.
    always_comb begin
        cnt_s = cnt_r;
        case ({in_valid, pop_s})
            2'b10:   cnt_s = cnt_r + 2'd1;
            2'b01:   cnt_s = cnt_r - 2'd1;
            default: cnt_s = cnt_r;
        endcase
    end

    // Storage shift/fill and registered valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0_r  <= {W{1'b0}};
            ent1_r  <= {W{1'b0}};
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            valid_r <= (cnt_s != 2'd0);
            case ({in_valid, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) ent0_r <= in_data;
                    else               ent1_r <= in_data;
                end
                2'b01: ent0_r <= ent1_r;
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        ent0_r <= in_data;
                    end else begin
                        ent0_r <= ent1_r;
                        ent1_r <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_weight_stream.sv
// Weight SRAM with a burst read engine. Words are written through a direct
// port; a (start_addr, burst_len) request streams consecutive words out on a
// valid/ready interface through a 2-entry FIFO. Build option
// SRAM_WEIGHT_PARITY_EN adds a stored even-parity bit per word and flags
// mismatching words on rd_perr.
module sram_weight_stream
    import sram_weight_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_perr
);

`ifdef SRAM_WEIGHT_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        if (a == LAST_ADDR) r = {ADDR_W{1'b0}};
        else                r = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        return r;
    endfunction

    logic [MEM_W-1:0]  mem_r [DEPTH];
    logic [MEM_W-1:0]  mem_q_r;
    logic              mem_vld_r;
    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [LEN_W-1:0]  rem_r;
    logic [LEN_W-1:0]  rem_s;
    logic              busy_r;
    logic              done_r;
    logic              done_s;
    logic              issue_s;
    logic              wr_take_s;
    logic              credit_s;
    logic              pop_s;
    logic [1:0]        occ_s;
    logic [1:0]        fifo_cnt_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [MEM_W-1:0]  wr_word_s;
    logic              perr_s;
    logic [DATA_W:0]   fifo_out_s;

    // Out-of-range writes are dropped and do not steal the read slot.
    assign wr_take_s = wr_en && ({1'b0, wr_addr} < DEPTH_X);
    assign pop_s     = rd_valid && rd_ready;
    // A word leaving the FIFO this cycle frees its slot for the read issued now.
    assign occ_s     = {1'b0, mem_vld_r} + fifo_cnt_s;
    assign credit_s  = (occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s);
    // The first read of a burst is issued straight from start_addr.
    assign rd_addr_s = (state_r == IDLE) ? start_addr : addr_r;

`ifdef SRAM_WEIGHT_PARITY_EN
    assign wr_word_s = {even_parity(PAR_MAX_W'(wr_data)), wr_data};
    assign perr_s    = even_parity(PAR_MAX_W'(mem_q_r[DATA_W-1:0])) != mem_q_r[DATA_W];
`else
    assign wr_word_s = wr_data;
    assign perr_s    = 1'b0;
`endif

    // Burst sequencing: accept request, issue reads under credit, drain.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        rem_s   = rem_r;
        issue_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (burst_len == LEN_ZERO) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = STREAM;
                        if (!wr_take_s) begin
                            issue_s = 1'b1;
                            addr_s  = next_addr(start_addr);
                            rem_s   = burst_len - LEN_ONE;
                        end else begin
                            addr_s  = start_addr;
                            rem_s   = burst_len;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (rem_r == LEN_ZERO) begin
                    state_s = DRAIN;
                end else if (!wr_take_s && credit_s) begin
                    issue_s = 1'b1;
                    addr_s  = next_addr(addr_r);
                    rem_s   = rem_r - LEN_ONE;
                    if (rem_r == LEN_ONE) state_s = DRAIN;
                    else                  state_s = STREAM;
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: begin
                if (!mem_vld_r &&
                    ((fifo_cnt_s == 2'd0) || ((fifo_cnt_s == 2'd1) && pop_s))) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Single-port array: a write wins the port, otherwise a registered read.
    always_ff @(posedge clk) begin
        if (wr_take_s) begin
            mem_r[wr_addr] <= wr_word_s;
        end else if (issue_s) begin
            mem_q_r <= mem_r[rd_addr_s];
        end
    end

    // FSM, burst pointers, in-flight flag and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            addr_r    <= {ADDR_W{1'b0}};
            rem_r     <= LEN_ZERO;
            mem_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            rem_r     <= rem_s;
            mem_vld_r <= issue_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= done_s;
        end
    end

    sram_weight_skid_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mem_vld_r),
        .in_data   ({perr_s, mem_q_r[DATA_W-1:0]}),
        .out_valid (rd_valid),
        .out_data  (fifo_out_s),
        .out_ready (rd_ready),
        .count     (fifo_cnt_s)
    );

    assign rd_data = fifo_out_s[DATA_W-1:0];
    assign rd_perr = fifo_out_s[DATA_W];
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_sram_weight_stream.sv
// Self-checking bench for sram_weight_stream. A word-level memory model and
// an expected-word queue per burst predict every streamed word; cycle
// expectations (latency, done/busy timing) follow the block's timing rules.
module tb_sram_weight_stream;

    localparam int DEPTH = 156800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [17:0] start_addr;
    logic [17:0] burst_len;
    logic        busy;
    logic        done;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_perr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] model_mem [int];
    bit          model_bad [int];

    always #5 clk = ~clk;

    sram_weight_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .start_addr (start_addr),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_perr    (rd_perr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 18'(a);
        wr_data = d;
        model_mem[a] = d;
        if (model_bad.exists(a)) model_bad.delete(a);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
    task automatic run_burst(input int a, input int len, input int ready_mode,
                             input bit wr_mode, input bit poke,
                             output int done_c, output int first_valid);
        logic [16:0] exp_q[$];
        logic [16:0] w;
        logic [15:0] held_data;
        bit          held_valid;
        bit          busy_exp;
        bit          done_exp;
        int          hs;
        int          last_hs;
        int          ai;
        hs = 0; last_hs = 0; held_valid = 1'b0; held_data = 16'h0;
        done_c = -1; first_valid = -1;
        for (int i = 0; i < len; i++) begin
            ai = (a + i) % DEPTH;
            exp_q.push_back({model_bad.exists(ai) ? 1'b1 : 1'b0, model_mem[ai]});
        end
        @(negedge clk);
        rd_ready   = 1'b0;
        start      = 1'b1;
        start_addr = 18'(a);
        burst_len  = 18'(len);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            case (ready_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (c % 3 == 1);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            wr_en = 1'b0;
            if (wr_mode && c <= 7 && (c % 2 == 1)) begin
                wr_en   = 1'b1;
                wr_addr = 18'(100 + c);
                wr_data = 16'($urandom);
                model_mem[100 + c] = wr_data;
            end
            if (poke && c == 3) begin
                start      = 1'b1;
                start_addr = 18'(a + 50);
                burst_len  = 18'd5;
            end else begin
                start = 1'b0;
            end
            busy_exp = (len != 0) && !(hs == len && c > last_hs);
            done_exp = (len == 0) ? (c == 1) : (hs == len && c == last_hs + 1);
            check("busy", busy, busy_exp);
            check("done", done, done_exp);
            if (done && done_c < 0) done_c = c;
            if (len == 0) check("len0_valid", rd_valid, 0);
            if (held_valid) begin
                check("stall_valid", rd_valid, 1);
                check("stall_data", rd_data, held_data);
            end
            if (rd_valid && first_valid < 0) first_valid = c;
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", hs + 1, len);
                end else begin
                    w = exp_q.pop_front();
                    check("data", rd_data, w[15:0]);
                    check("perr", rd_perr, w[16]);
                end
                hs++;
                last_hs    = c;
                held_valid = 1'b0;
            end else if (rd_valid) begin
                held_valid = 1'b1;
                held_data  = rd_data;
            end else begin
                held_valid = 1'b0;
            end
            if ((len == 0 && c >= 4) || (len != 0 && hs == len && c >= last_hs + 2)) break;
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b0;
        check("all_words", hs, len);
        check("done_seen", (done_c >= 0), 1);
        check("leftover", exp_q.size(), 0);
    endtask

    int dc, fv, hs3, ra, rl;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_addr = '0; burst_len = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_perr", rd_perr, 0);
        rst_n = 1'b1;

        // Basic 8-word burst, always ready: latency 2, back-to-back words.
        for (int i = 0; i < 8; i++) write_word(i, 16'(16'h1000 + i));
        run_burst(0, 8, 0, 1'b0, 1'b0, dc, fv);
        check("first_valid_lat", fv, 2);
        check("done_cycle", dc, 10);

        // Wrap from the last address to 0.
        write_word(156798, 16'($urandom));
        write_word(156799, 16'($urandom));
        write_word(0, 16'($urandom));
        write_word(1, 16'($urandom));
        run_burst(156798, 4, 0, 1'b0, 1'b0, dc, fv);
        check("wrap_lat", fv, 2);
        check("wrap_done", dc, 6);

        // Backpressure 1,0,0 pattern over 6 words.
        for (int i = 0; i < 8; i++) write_word(i, 16'($urandom));
        run_burst(2, 6, 1, 1'b0, 1'b0, dc, fv);

        // Four interleaved writes each steal one read slot.
        run_burst(0, 8, 0, 1'b1, 1'b0, dc, fv);
        check("wr_stall_done", dc, 8 + 2 + 4);

        // Zero-length burst, then a start poked while busy.
        run_burst(5, 0, 0, 1'b0, 1'b0, dc, fv);
        check("len0_done", dc, 1);
        run_burst(0, 8, 0, 1'b0, 1'b1, dc, fv);
        check("poke_done", dc, 10);

        // Reset after three words of a burst.
        @(negedge clk);
        start = 1'b1; start_addr = 18'd0; burst_len = 18'd8; rd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs3 = 0;
        for (int c = 0; c < 20 && hs3 < 3; c++) begin
            if (rd_valid && rd_ready) hs3++;
            @(negedge clk);
        end
        check("pre_rst_words", hs3, 3);
        rst_n = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_perr", rd_perr, 0);
        rd_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_valid", rd_valid, 0);
        end
        run_burst(3, 5, 0, 1'b0, 1'b0, dc, fv);
        check("post_rst_burst", dc, 7);

        // Randomized bursts, including wrap, with random backpressure.
        for (int i = 0; i < 32; i++) write_word(i, 16'($urandom));
        for (int i = 156784; i < DEPTH; i++) write_word(i, 16'($urandom));
        for (int k = 0; k < 8; k++) begin
            rl = $urandom_range(1, 12);
            if ($urandom_range(0, 1) == 1) ra = $urandom_range(0, 16);
            else                           ra = 156784 + $urandom_range(0, 15);
            run_burst(ra, rl, 2, 1'b0, 1'b0, dc, fv);
        end

`ifdef SRAM_WEIGHT_PARITY_EN
        // Corrupt one stored bit: only that word carries rd_perr.
        for (int i = 0; i < 4; i++) write_word(300 + i, 16'($urandom));
        dut.mem_r[301] = dut.mem_r[301] ^ 17'h00008;
        model_bad[301] = 1'b1;
        run_burst(300, 4, 1, 1'b0, 1'b0, dc, fv);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
